// File: rtl/rename_map_table.sv
// 3-wide rename map table: source lookup with ready bits, destination allocation, Told for the ROB.
// Latency: lookups are combinational (0 cycles); table updates commit at the next clock edge.
// Backpressure: none; upstream gates inst_valid/has_dest with free-list availability.
//
// Ports: clock/reset (async, active-high); per-slot dispatch inputs inst_valid, has_dest,
// dest_areg, src1_areg, src2_areg, free_preg; CDB lanes cdb_en/cdb_preg; recover_en + arch_map
// for branch recovery. Outputs src1/src2 preg+ready, dest_preg, told_preg per slot.
// Slot 2 is the oldest instruction in the group, slot 0 the youngest.
module rename_map_table #(
    parameter int NUM_AREG = 32,
    parameter int AREG_W   = 5,
    parameter int PR_W     = 6
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [2:0]                         inst_valid,
    input  logic [2:0]                         has_dest,
    input  logic [2:0][AREG_W-1:0]             dest_areg,
    input  logic [2:0][AREG_W-1:0]             src1_areg,
    input  logic [2:0][AREG_W-1:0]             src2_areg,
    input  logic [2:0][PR_W-1:0]               free_preg,
    input  logic [2:0]                         cdb_en,
    input  logic [2:0][PR_W-1:0]               cdb_preg,
    input  logic                               recover_en,
    input  logic [NUM_AREG-1:0][PR_W-1:0]      arch_map,
    output logic [2:0][PR_W-1:0]               src1_preg,
    output logic [2:0]                         src1_ready,
    output logic [2:0][PR_W-1:0]               src2_preg,
    output logic [2:0]                         src2_ready,
    output logic [2:0][PR_W-1:0]               dest_preg,
    output logic [2:0][PR_W-1:0]               told_preg
);

    logic [NUM_AREG-1:0][PR_W-1:0] map_q, map_d;
    logic [NUM_AREG-1:0]           rdy_q, rdy_d;
    logic [NUM_AREG-1:0]           written;

    // A slot only renames when it is both valid and has a destination.
    logic [2:0] wr_en;
    assign wr_en = inst_valid & has_dest;

    // Source lookup for slot s: table, then nearest older in-group writer,
    // then CDB wakeup on the selected preg, then the hardwired-zero register.
    // Returns {ready, preg}.
    function automatic logic [PR_W:0] lookup(input int s, input logic [AREG_W-1:0] a);
        logic [PR_W-1:0] p;
        logic            r;
        p = map_q[a];
        r = rdy_q[a];
        // Walk oldest to youngest so the nearest older writer is applied last.
        for (int k = 2; k > s; k--) begin
            if (wr_en[k] && dest_areg[k] == a) begin
                p = free_preg[k];
                r = 1'b0;
            end
        end
        for (int l = 0; l < 3; l++) begin
            if (cdb_en[l] && cdb_preg[l] == p) r = 1'b1;
        end
        if (a == '0) begin
            p = '0;
            r = 1'b1;
        end
        return {r, p};
    endfunction

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            src1_preg[s]  = '0;
            src1_ready[s] = 1'b0;
            src2_preg[s]  = '0;
            src2_ready[s] = 1'b0;
            dest_preg[s]  = '0;
            told_preg[s]  = '0;
            if (inst_valid[s]) begin
                {src1_ready[s], src1_preg[s]} = lookup(s, src1_areg[s]);
                {src2_ready[s], src2_preg[s]} = lookup(s, src2_areg[s]);
                if (has_dest[s]) begin
                    dest_preg[s] = free_preg[s];
                    told_preg[s] = map_q[dest_areg[s]];
                    for (int k = 2; k > s; k--) begin
                        if (wr_en[k] && dest_areg[k] == dest_areg[s]) told_preg[s] = free_preg[k];
                    end
                end
            end
        end
    end

    always_comb begin
        map_d   = map_q;
        rdy_d   = rdy_q;
        written = '0;
        if (recover_en) begin
            map_d = arch_map;
            rdy_d = '1;
        end else begin
            // Oldest first so the youngest slot wins an intra-group WAW.
            for (int k = 2; k >= 0; k--) begin
                if (wr_en[k] && dest_areg[k] != '0) begin
                    map_d[dest_areg[k]]   = free_preg[k];
                    rdy_d[dest_areg[k]]   = 1'b0;
                    written[dest_areg[k]] = 1'b1;
                end
            end
            // Wakeup only applies to entries keeping their old mapping; freshly
            // allocated pregs cannot be in flight on the CDB.
            for (int a = 0; a < NUM_AREG; a++) begin
                for (int l = 0; l < 3; l++) begin
                    if (!written[a] && cdb_en[l] && map_q[a] == cdb_preg[l]) rdy_d[a] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_AREG; i++) map_q[i] <= PR_W'(i);
            rdy_q <= '1;
        end else begin
            map_q <= map_d;
            rdy_q <= rdy_d;
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: hand-computed vectors for lookup, bypass, Told,
// CDB wakeup, recovery and asynchronous reset.
// Inputs change on the falling edge; outputs are checked 1 ns later, state commits on the rising edge.
module tb_rename_map_table;

    localparam int NUM_AREG = 32;
    localparam int AREG_W   = 5;
    localparam int PR_W     = 6;

    logic                          clock;
    logic                          reset;
    logic [2:0]                    inst_valid;
    logic [2:0]                    has_dest;
    logic [2:0][AREG_W-1:0]        dest_areg;
    logic [2:0][AREG_W-1:0]        src1_areg;
    logic [2:0][AREG_W-1:0]        src2_areg;
    logic [2:0][PR_W-1:0]          free_preg;
    logic [2:0]                    cdb_en;
    logic [2:0][PR_W-1:0]          cdb_preg;
    logic                          recover_en;
    logic [NUM_AREG-1:0][PR_W-1:0] arch_map;
    logic [2:0][PR_W-1:0]          src1_preg;
    logic [2:0]                    src1_ready;
    logic [2:0][PR_W-1:0]          src2_preg;
    logic [2:0]                    src2_ready;
    logic [2:0][PR_W-1:0]          dest_preg;
    logic [2:0][PR_W-1:0]          told_preg;

    int total = 0;
    int bad   = 0;

    rename_map_table #(.NUM_AREG(NUM_AREG), .AREG_W(AREG_W), .PR_W(PR_W)) dut (
        .clock(clock), .reset(reset), .inst_valid(inst_valid), .has_dest(has_dest),
        .dest_areg(dest_areg), .src1_areg(src1_areg), .src2_areg(src2_areg),
        .free_preg(free_preg), .cdb_en(cdb_en), .cdb_preg(cdb_preg),
        .recover_en(recover_en), .arch_map(arch_map),
        .src1_preg(src1_preg), .src1_ready(src1_ready), .src2_preg(src2_preg),
        .src2_ready(src2_ready), .dest_preg(dest_preg), .told_preg(told_preg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Next falling edge with all dispatch/CDB inputs cleared.
    task automatic step();
        @(negedge clock);
        inst_valid = '0; has_dest = '0; dest_areg = '0; src1_areg = '0; src2_areg = '0;
        free_preg = '0; cdb_en = '0; cdb_preg = '0; recover_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        inst_valid = '0; has_dest = '0; dest_areg = '0; src1_areg = '0; src2_areg = '0;
        free_preg = '0; cdb_en = '0; cdb_preg = '0; recover_en = 1'b0;
        for (int i = 0; i < NUM_AREG; i++) arch_map[i] = PR_W'(i);
        arch_map[9] = 6'd20;
        #12 reset = 1'b0;

        // Identity after reset; slot1 sees slot2's new r7 mapping in-group.
        step();
        inst_valid = 3'b110; has_dest = 3'b100;
        dest_areg[2] = 5'd7; src1_areg[2] = 5'd7; free_preg[2] = 6'd33;
        src1_areg[1] = 5'd7; src2_areg[1] = 5'd0; src1_areg[0] = 5'd7;
        #1;
        chk("rst_src1_preg", src1_preg[2], 7);
        chk("rst_src1_rdy", src1_ready[2], 1);
        chk("rst_told", told_preg[2], 7);
        chk("rst_dest", dest_preg[2], 33);
        chk("byp_r7_preg", src1_preg[1], 33);
        chk("byp_r7_rdy", src1_ready[1], 0);
        chk("r0_preg", src2_preg[1], 0);
        chk("r0_rdy", src2_ready[1], 1);
        chk("nodest_told", told_preg[1], 0);
        chk("invalid_slot", src1_preg[0], 0);

        // Slot2 writes r3<-p40; younger slots read r3.
        step();
        inst_valid = 3'b111; has_dest = 3'b100;
        dest_areg[2] = 5'd3; free_preg[2] = 6'd40; src1_areg[2] = 5'd7;
        src1_areg[1] = 5'd3; src2_areg[0] = 5'd3;
        #1;
        chk("r7_map_preg", src1_preg[2], 33);
        chk("r7_map_rdy", src1_ready[2], 0);
        chk("told_r3", told_preg[2], 3);
        chk("byp_s1_preg", src1_preg[1], 40);
        chk("byp_s1_rdy", src1_ready[1], 0);
        chk("byp_s0_preg", src2_preg[0], 40);

        // Three-way WAW on r5.
        step();
        inst_valid = 3'b111; has_dest = 3'b111;
        dest_areg = {5'd5, 5'd5, 5'd5}; free_preg = {6'd40, 6'd41, 6'd42};
        src1_areg[2] = 5'd3; src1_areg[1] = 5'd5; src2_areg[0] = 5'd5;
        #1;
        chk("r3_next_preg", src1_preg[2], 40);
        chk("r3_next_rdy", src1_ready[2], 0);
        chk("waw_told2", told_preg[2], 5);
        chk("waw_told1", told_preg[1], 40);
        chk("waw_told0", told_preg[0], 41);
        chk("waw_src_s1", src1_preg[1], 40);
        chk("waw_src_s0", src2_preg[0], 41);

        // CDB wakes p42 (r5) in the same cycle; r3 (p40) stays not ready.
        step();
        inst_valid = 3'b001; src1_areg[0] = 5'd5; src2_areg[0] = 5'd3;
        cdb_en = 3'b010; cdb_preg[1] = 6'd42;
        #1;
        chk("waw_map_r5", src1_preg[0], 42);
        chk("cdb_byp_rdy", src1_ready[0], 1);
        chk("cdb_nomatch_rdy", src2_ready[0], 0);

        // Dispatch overwrites r3 while CDB broadcasts p40 (old r3) and p33 (r7).
        step();
        inst_valid = 3'b100; has_dest = 3'b100; dest_areg[2] = 5'd3; free_preg[2] = 6'd50;
        src1_areg[2] = 5'd5; src2_areg[2] = 5'd3;
        cdb_en = 3'b101; cdb_preg[0] = 6'd40; cdb_preg[2] = 6'd33;
        #1;
        chk("r5_rdy_commit", src1_ready[2], 1);
        chk("cdb_byp_r3", src2_ready[2], 1);

        // Rename r4->p51; r3 keeps fresh p50 not ready, r7 woke.
        step();
        inst_valid = 3'b100; has_dest = 3'b100; dest_areg[2] = 5'd4; free_preg[2] = 6'd51;
        src1_areg[2] = 5'd3; src2_areg[2] = 5'd7;
        #1;
        chk("ovr_r3_preg", src1_preg[2], 50);
        chk("ovr_r3_rdy", src1_ready[2], 0);
        chk("cdb_r7_rdy", src2_ready[2], 1);
        chk("told_r4", told_preg[2], 4);

        step();
        inst_valid = 3'b001; src1_areg[0] = 5'd4;
        #1;
        chk("r4_renamed", src1_preg[0], 51);

        // Recovery with a concurrent dispatch of r6<-p52 (dispatch is discarded).
        step();
        recover_en = 1'b1;
        inst_valid = 3'b100; has_dest = 3'b100; dest_areg[2] = 5'd6; free_preg[2] = 6'd52;

        step();
        inst_valid = 3'b111;
        src1_areg[2] = 5'd4; src2_areg[2] = 5'd6;
        src1_areg[1] = 5'd9; src2_areg[1] = 5'd3; src1_areg[0] = 5'd5;
        #1;
        chk("rec_r4_preg", src1_preg[2], 4);
        chk("rec_r4_rdy", src1_ready[2], 1);
        chk("rec_r6_lost", src2_preg[2], 6);
        chk("rec_r9_arch", src1_preg[1], 20);
        chk("rec_r9_rdy", src1_ready[1], 1);
        chk("rec_r3_rdy", src2_ready[1], 1);
        chk("rec_r5_preg", src1_preg[0], 5);

        // Async reset between edges restores identity immediately.
        step();
        inst_valid = 3'b100; has_dest = 3'b100; dest_areg[2] = 5'd8; free_preg[2] = 6'd60;
        step();
        inst_valid = 3'b100; src1_areg[2] = 5'd8; src2_areg[2] = 5'd9;
        #1;
        chk("r8_renamed", src1_preg[2], 60);
        #1 reset = 1'b1;
        #1;
        chk("arst_r8_preg", src1_preg[2], 8);
        chk("arst_r8_rdy", src1_ready[2], 1);
        chk("arst_r9_preg", src2_preg[2], 9);
        step();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
